// File: rtl/open_mem_reader.sv
// open_mem_reader: snapshots the open_mem lane bus on a start request and
// streams a contiguous, wrapping run of lanes out as a valid/ready byte stream.
// Every output comes straight from a flop, so i_ready never reaches an output
// combinationally.
module open_mem_reader #(
  parameter int AWIDTH = 2,
  parameter int DWIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [(2**AWIDTH)*DWIDTH-1:0]     i_datalane,
  input  logic                              i_start,
  input  logic [AWIDTH-1:0]                 i_first_lane,
  input  logic [AWIDTH:0]                   i_count,
  input  logic                              i_ready,
  output logic                              o_valid,
  output logic [DWIDTH-1:0]                 o_data,
  output logic [AWIDTH-1:0]                 o_lane,
  output logic                              o_last,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_err
);

  localparam int NLANES = 2**AWIDTH;
  localparam logic [AWIDTH:0] NLANES_C = (AWIDTH+1)'(NLANES);
  localparam logic [AWIDTH:0] ONE_C    = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0] TWO_C    = (AWIDTH+1)'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [NLANES*DWIDTH-1:0]   shadow_q, shadow_d;
  logic [AWIDTH-1:0]          ptr_q, ptr_d;
  logic [AWIDTH:0]            rem_q, rem_d;
  logic                       valid_q, valid_d;
  logic [DWIDTH-1:0]          data_q, data_d;
  logic [AWIDTH-1:0]          lane_q, lane_d;
  logic                       last_q, last_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic                       countOk;
  logic [AWIDTH-1:0]          ptrInc;

  // Picks one DWIDTH-wide lane out of a flattened lane bus.
  function automatic logic [DWIDTH-1:0] laneOf(
    input logic [NLANES*DWIDTH-1:0] bus,
    input logic [AWIDTH-1:0]        idx
  );
    logic [DWIDTH-1:0] sel;
    sel = '0;
    for (int k = 0; k < NLANES; k++) begin
      if (idx == AWIDTH'(k)) sel = bus[k*DWIDTH +: DWIDTH];
    end
    return sel;
  endfunction

  // A run length is usable only when it is between one and the lane count.
  assign countOk = (i_count != '0) && (i_count <= NLANES_C);

  // Pointer advance wraps naturally at the lane count.
  assign ptrInc = ptr_q + AWIDTH'(1);

  // Next-state and next-output decode; outputs are precomputed here so that
  // each beat appears on the flops in the same cycle the state reaches it.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    valid_d  = valid_q;
    data_d   = data_q;
    lane_d   = lane_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = '0;
        lane_d  = '0;
        last_d  = 1'b0;
        if (i_start) begin
          if (countOk) begin
            shadow_d = i_datalane;
            ptr_d    = i_first_lane;
            rem_d    = i_count;
            state_d  = SEND;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            data_d   = laneOf(i_datalane, i_first_lane);
            lane_d   = i_first_lane;
            last_d   = (i_count == ONE_C);
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SEND: begin
        if (i_ready) begin
          ptr_d = ptrInc;
          rem_d = rem_q - ONE_C;
          if (rem_q == ONE_C) begin
            state_d = DONE;
            valid_d = 1'b0;
            data_d  = '0;
            lane_d  = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d = laneOf(shadow_q, ptrInc);
            lane_d = ptrInc;
            last_d = (rem_q == TWO_C);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, snapshot and registered outputs, cleared synchronously by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      ptr_q    <= '0;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      lane_q   <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      lane_q   <= lane_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_lane  = lane_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_open_mem_reader.sv
// Testbench for open_mem_reader: directed steps drive runs, a scoreboard queue
// holds the expected beats and a negedge monitor pops them on each handshake.
module tb_open_mem_reader;

  localparam int AWIDTH = 2;
  localparam int DWIDTH = 8;
  localparam int NLANES = 2**AWIDTH;

  typedef struct {
    logic [DWIDTH-1:0] data;
    logic [AWIDTH-1:0] lane;
    logic              last;
  } beat_t;

  logic                      clk;
  logic                      rst;
  logic [NLANES*DWIDTH-1:0]  i_datalane;
  logic                      i_start;
  logic [AWIDTH-1:0]         i_first_lane;
  logic [AWIDTH:0]           i_count;
  logic                      i_ready;
  logic                      o_valid;
  logic [DWIDTH-1:0]         o_data;
  logic [AWIDTH-1:0]         o_lane;
  logic                      o_last;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_err;

  beat_t sbQ[$];
  int    checks = 0;
  int    errors = 0;
  int    doneCount = 0;
  int    errCount = 0;

  open_mem_reader #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_datalane   (i_datalane),
    .i_start      (i_start),
    .i_first_lane (i_first_lane),
    .i_count      (i_count),
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_lane       (o_lane),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports and counts a failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start request for one cycle and queue the beats it should yield.
  task automatic applyStimulus(input logic [AWIDTH-1:0] first, input logic [AWIDTH:0] count,
                               input logic [NLANES*DWIDTH-1:0] lanes);
    beat_t b;
    int    ln;
    i_datalane   = lanes;
    i_first_lane = first;
    i_count      = count;
    i_start      = 1'b1;
    if (count >= 1 && count <= NLANES) begin
      for (int k = 0; k < int'(count); k++) begin
        ln     = (int'(first) + k) % NLANES;
        b.lane = AWIDTH'(ln);
        b.data = lanes[ln*DWIDTH +: DWIDTH];
        b.last = (k == int'(count) - 1);
        sbQ.push_back(b);
      end
    end
    tick();
    i_start = 1'b0;
  endtask

  // Wait a bounded number of cycles for o_done, then confirm the run drained.
  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_done && n < budget) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, 32'(o_done), 32'd1);
    checkOutput({tag, "_sb_empty"}, 32'(sbQ.size()), 32'd0);
    tick();
  endtask

  // Monitor: pops and compares a scoreboard entry on every accepted beat.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && o_valid && i_ready) begin
      checkOutput("sb_has_entry", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkOutput("beat_data", 32'(o_data), 32'(e.data));
        checkOutput("beat_lane", 32'(o_lane), 32'(e.lane));
        checkOutput("beat_last", 32'(o_last), 32'(e.last));
      end
    end
    if (!rst && o_done) doneCount++;
    if (!rst && o_err)  errCount++;
  end

  initial begin
    int doneBefore;
    int errBefore;

    rst          = 1'b1;
    i_datalane   = '0;
    i_start      = 1'b0;
    i_first_lane = '0;
    i_count      = '0;
    i_ready      = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_data",  32'(o_data),  32'd0);
    checkOutput("rst_lane",  32'(o_lane),  32'd0);
    checkOutput("rst_last",  32'(o_last),  32'd0);
    checkOutput("rst_busy",  32'(o_busy),  32'd0);
    checkOutput("rst_done",  32'(o_done),  32'd0);
    checkOutput("rst_err",   32'(o_err),   32'd0);
    tick();

    // Full run with exact cycle timing
    $display("[TB] full run");
    applyStimulus(2'd0, 3'd4, 32'h44332211);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("full_valid", 32'(o_valid), 32'd1);
      checkOutput("full_busy",  32'(o_busy),  32'd1);
      checkOutput("full_last",  32'(o_last),  32'(c == 3));
      tick();
    end
    @(negedge clk);
    checkOutput("full_done",       32'(o_done),  32'd1);
    checkOutput("full_done_valid", 32'(o_valid), 32'd0);
    checkOutput("full_done_busy",  32'(o_busy),  32'd1);
    tick();
    @(negedge clk);
    checkOutput("full_idle_busy", 32'(o_busy), 32'd0);
    checkOutput("full_idle_done", 32'(o_done), 32'd0);
    checkOutput("full_sb_empty",  32'(sbQ.size()), 32'd0);
    tick();

    // Wrap from the top lane
    $display("[TB] wrap");
    applyStimulus(2'd3, 3'd2, 32'h44332211);
    waitDone("wrap", 10);

    // Backpressure on the second beat
    $display("[TB] backpressure");
    applyStimulus(2'd1, 3'd3, 32'h44332211);
    tick();
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(o_valid), 32'd1);
      checkOutput("bp_data",  32'(o_data),  32'h33);
      checkOutput("bp_lane",  32'(o_lane),  32'd2);
      checkOutput("bp_last",  32'(o_last),  32'd0);
      tick();
    end
    i_ready = 1'b1;
    waitDone("bp", 10);

    // Snapshot isolation and ignored mid-run start
    $display("[TB] snapshot");
    errBefore  = errCount;
    doneBefore = doneCount;
    applyStimulus(2'd0, 3'd4, 32'h44332211);
    i_datalane = 32'hDDCCBBAA;
    tick();
    i_start      = 1'b1;
    i_first_lane = 2'd2;
    i_count      = 3'd0;
    tick();
    i_start = 1'b0;
    waitDone("snap", 10);
    @(negedge clk);
    checkOutput("snap_no_restart", 32'(o_valid), 32'd0);
    checkOutput("snap_idle_busy",  32'(o_busy),  32'd0);
    checkOutput("snap_no_err",     32'(errCount - errBefore),   32'd0);
    checkOutput("snap_one_done",   32'(doneCount - doneBefore), 32'd1);
    tick();

    // Bad counts: zero, over range, and zero held two cycles
    $display("[TB] bad count");
    applyStimulus(2'd1, 3'd0, 32'h44332211);
    @(negedge clk);
    checkOutput("bad0_err",   32'(o_err),   32'd1);
    checkOutput("bad0_valid", 32'(o_valid), 32'd0);
    checkOutput("bad0_busy",  32'(o_busy),  32'd0);
    tick();
    @(negedge clk);
    checkOutput("bad0_err_clear", 32'(o_err), 32'd0);
    tick();
    applyStimulus(2'd0, 3'd5, 32'h44332211);
    @(negedge clk);
    checkOutput("bad5_err",   32'(o_err),   32'd1);
    checkOutput("bad5_valid", 32'(o_valid), 32'd0);
    checkOutput("bad5_busy",  32'(o_busy),  32'd0);
    tick();
    @(negedge clk);
    checkOutput("bad5_err_clear", 32'(o_err), 32'd0);
    tick();
    i_count = 3'd0;
    i_start = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("hold_err1", 32'(o_err), 32'd1);
    tick();
    i_start = 1'b0;
    @(negedge clk);
    checkOutput("hold_err2", 32'(o_err), 32'd1);
    tick();
    @(negedge clk);
    checkOutput("hold_err_clear", 32'(o_err), 32'd0);
    tick();

    // Reset in the middle of a run, then a clean run
    $display("[TB] reset mid-run");
    doneBefore = doneCount;
    applyStimulus(2'd0, 3'd4, 32'h44332211);
    tick();
    tick();
    rst = 1'b1;
    sbQ.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mrst_valid", 32'(o_valid), 32'd0);
    checkOutput("mrst_data",  32'(o_data),  32'd0);
    checkOutput("mrst_lane",  32'(o_lane),  32'd0);
    checkOutput("mrst_last",  32'(o_last),  32'd0);
    checkOutput("mrst_busy",  32'(o_busy),  32'd0);
    checkOutput("mrst_done",  32'(o_done),  32'd0);
    tick();
    tick();
    tick();
    checkOutput("mrst_no_done", 32'(doneCount - doneBefore), 32'd0);
    applyStimulus(2'd2, 3'd4, 32'h8877_6655);
    waitDone("mrst_fresh", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/open_mem_reader.md
# open_mem_reader

Read-side companion to `open_mem`. It snapshots the flattened lane bus `o_datalane` on a start request and streams a contiguous run of lanes out over a valid/ready byte stream, wrapping modulo the lane count. The write side fills `open_mem`. This block drains it towards downstream consumers, such as a debug/trace port or the register-file loader.

## Interface
Parameters:
- `AWIDTH`, 2: lane-index width; `NLANES = 2**AWIDTH` (localparam).
- `DWIDTH`, 8: lane data width.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_datalane`  in  NLANES*DWIDTH  lane bus from `open_mem`; lane k = bits [k*DWIDTH +: DWIDTH].
- `i_start`  in  1  start request, sampled in IDLE only.
- `i_first_lane`  in  AWIDTH  first lane to send.
- `i_count`  in  AWIDTH+1  number of lanes to send; valid range 1..NLANES.
- `i_ready`  in  1  downstream ready.
- `o_valid`  out  1  beat valid.
- `o_data`  out  DWIDTH  beat data.
- `o_lane`  out  AWIDTH  lane index of current beat.
- `o_last`  out  1  current beat is final of run.
- `o_busy`  out  1  high in SEND and DONE.
- `o_done`  out  1  one-cycle pulse after final beat accepted.
- `o_err`  out  1  one-cycle pulse on rejected start.

## Operation
- Three states: IDLE, SEND, DONE.
- **IDLE**
  - When `i_start`=1 and 1 ≤ `i_count` ≤ NLANES:
    - capture all of `i_datalane` into a shadow register;
    - load the lane pointer with `i_first_lane`;
    - load the remaining counter with `i_count`;
    - go to SEND.
  - When `i_start`=1 and `i_count`=0 or `i_count` > NLANES: pulse `o_err` next cycle and stay in IDLE.
- **SEND**
  - `o_valid`=1.
  - `o_data` = shadow lane[pointer].
  - `o_lane` = pointer.
  - `o_last` = (remaining == 1).
  - On handshake (`o_valid && i_ready`):
    - pointer increments modulo NLANES (natural AWIDTH-bit wrap);
    - remaining decrements;
    - if the beat was last, go to DONE.
- **DONE**
  - `o_done`=1, `o_busy`=1, `o_valid`=0 for exactly one cycle.
  - Then return to IDLE.
- `i_start` in SEND or DONE is ignored: no error, no restart.
- Data comes only from the snapshot. Changes on `i_datalane` after the start cycle do not affect the run.
- Outputs are registered or decoded from registered state only. There is no combinational path from `i_ready` to any output.

## Timing
- Reset values:
  - state = IDLE;
  - `o_valid`=0, `o_data`=0, `o_lane`=0, `o_last`=0, `o_busy`=0, `o_done`=0, `o_err`=0;
  - shadow register = 0.
- Start latency: start sampled at edge N; the first beat is valid in cycle N+1.
- With `i_ready` held high, one beat per cycle. A run of C lanes occupies cycles N+1..N+C, and `o_done` is high in cycle N+C+1.
- Back-to-back runs: the earliest next start is sampled in the cycle after DONE (IDLE). Minimum gap is 2 cycles without `o_valid`.
- Backpressure: while `o_valid`=1 and `i_ready`=0, `o_data`, `o_lane` and `o_last` hold stable.
- `i_ready` may toggle freely. `o_valid` never drops mid-run.
- `o_err` asserts one cycle after the bad start and lasts one cycle. A bad start held for k cycles gives k consecutive `o_err` cycles.
- `i_count`=NLANES with any `i_first_lane` sends every lane exactly once, with wrap.
- Reset in any state: on the next edge all state and outputs return to reset values. A partial run is abandoned with no `o_done`.

## Test plan
- **Full run.** Setup: `i_datalane`=0x44332211, first=0, count=4, `i_ready`=1. Required response:
  - data 0x11, 0x22, 0x33, 0x44 with lanes 0..3 on 4 consecutive cycles;
  - `o_last` only with 0x44;
  - `o_done` on the following cycle.
- **Wrap.** Setup: first=3, count=2. Required response:
  - beats (lane 3, 0x44) then (lane 0, 0x11, `o_last`=1);
  - then `o_done`.
- **Backpressure.** Setup: first=1, count=3, `i_ready` low for 3 cycles on the second beat. Required response:
  - 0x33 held stable with `o_valid`=1 during the stall;
  - total sequence 0x22, 0x33, 0x44.
- **Snapshot and ignored start.** Setup: change `i_datalane` to 0xDDCCBBAA one cycle after start and pulse `i_start` mid-run. Required response:
  - output is still the original 0x11..0x44;
  - no restart and no `o_err`.
- **Bad count.** Setup: `i_start` with count=0, then count=5 (AWIDTH=2). Required response:
  - one-cycle `o_err` each time;
  - `o_valid`/`o_busy` stay 0.
- **Reset mid-run.** Setup: assert `rst` after the second beat of a 4-lane run. Required response:
  - all outputs 0 on the next cycle;
  - no `o_done`;
  - a fresh start afterwards completes normally.
